// File: rtl/seq_mul_add_if.sv
// Handshake and operand bundle for the sequential multiply-accumulate.
// The master issues operands; the slave returns the registered result.
interface seq_mul_add_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   c_in;
  logic [2*WIDTH-1:0] product_out;
  logic               fits_out;
  logic               ready;
  logic               done;

  modport master (
    output start, a_in, b_in, c_in,
    input  product_out, fits_out, ready, done
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    output product_out, fits_out, ready, done
  );
endinterface

// File: rtl/seq_mul_add.sv
// Shift-and-add unsigned multiply-accumulate: product = a*b + c.
// One multiplier bit per clock, then one cycle for the addend.
module seq_mul_add #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_mul_add_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_c;
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_fits;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_res;
  logic               w_last;

  // hi keeps a carry bit so hi + a never wraps before the shift
  assign w_sum  = r_lo[0] ? (r_hi + {1'b0, r_a}) : r_hi;
  assign w_res  = {r_hi[WIDTH-1:0], r_lo} + {{WIDTH{1'b0}}, r_c};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_MUL;
      S_MUL:  if (w_last) w_next = S_ADD;
      S_ADD:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_c    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_prod <= '0;
      r_fits <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a_in;
            r_c   <= bus.c_in;
            r_hi  <= '0;
            r_lo  <= bus.b_in;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          r_hi  <= {1'b0, w_sum[WIDTH:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_ADD: begin
          r_prod <= w_res;
          r_fits <= (w_res[2*WIDTH-1:WIDTH] == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.product_out = r_prod;
  assign bus.fits_out    = r_fits;
  assign bus.ready       = (r_state == S_IDLE);
  assign bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add against a plain-arithmetic a*b+c model.
// Directed cases plus randomized operands, busy-start and reset-abort scenarios.
module tb_seq_mul_add;

  localparam int W  = 32;
  localparam int W2 = 2 * W;
  localparam int LAT = W + 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n_done;

  seq_mul_add_if #(.WIDTH(W)) bus();

  seq_mul_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done === 1'b1) n_done++;

  function automatic logic [W2-1:0] ref_mac(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c
  );
    return W2'(a) * W2'(b) + W2'(c);
  endfunction

  function automatic logic ref_fits(input logic [W2-1:0] p);
    return (p >> W) == 0;
  endfunction

  // Caller sits just after a negedge with ready high; returns at the
  // negedge where done is seen (or the bound expires).
  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output int           lat,
    output longint       t_acc,
    output bit           dropped
  );
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.c_in  = c;
    @(posedge clk);
    t_acc = longint'($time);
    #1;
    dropped   = !bus.ready;
    bus.start = 1'b0;
    lat = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && lat < 200) begin
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
      bus.c_in = W'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.c_in  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", bus.ready);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", bus.done);
    end
    checks++;
    if (bus.product_out !== '0) begin
      errors++;
      $display("FAIL reset_product got %h want 0", bus.product_out);
    end
    checks++;
    if (bus.fits_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_fits got %b want 1", bus.fits_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; longint t; bit dr; int n0;
    n0 = n_done;
    run_op(32'd25, 32'd2, 32'd0, lat, t, dr);
    checks++;
    if (dr !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_drop got ready_low=%b want 1", dr);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", lat, LAT);
    end
    checks++;
    if (bus.product_out !== 64'd50) begin
      errors++;
      $display("FAIL basic_product got %0d want 50", bus.product_out);
    end
    checks++;
    if (bus.fits_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_fits got %b want 1", bus.fits_out);
    end
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got ready=%b done=%b want 1 0",
               bus.ready, bus.done);
    end
    checks++;
    if (n_done - n0 != 1) begin
      errors++;
      $display("FAIL basic_done_count got %0d want 1", n_done - n0);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0]  va [5];
    logic [W-1:0]  vb [5];
    logic [W-1:0]  vc [5];
    logic [W2-1:0] exp_p;
    int lat; longint t; bit dr;
    va = '{32'd7, 32'h0000FFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    vb = '{32'd3, 32'h00010001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF};
    vc = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      exp_p = ref_mac(va[i], vb[i], vc[i]);
      run_op(va[i], vb[i], vc[i], lat, t, dr);
      checks++;
      if (bus.product_out !== exp_p || lat != LAT) begin
        errors++;
        $display("FAIL vec%0d_product got %h lat %0d want %h lat %0d",
                 i, bus.product_out, lat, exp_p, LAT);
      end
      checks++;
      if (bus.fits_out !== ref_fits(exp_p)) begin
        errors++;
        $display("FAIL vec%0d_fits got %b want %b",
                 i, bus.fits_out, ref_fits(exp_p));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_hold;
    int lat; longint t; bit dr; bit held; int cyc;
    run_op(32'h12345678, 32'd0, 32'd5, lat, t, dr);
    checks++;
    if (bus.product_out !== 64'd5 || bus.fits_out !== 1'b1) begin
      errors++;
      $display("FAIL zero_b got %h fits %b want 5 fits 1",
               bus.product_out, bus.fits_out);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'd0;
    bus.b_in  = 32'd9;
    bus.c_in  = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    held = 1'b1;
    cyc  = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.product_out !== 64'd5) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL zero_hold got held=%b want 1", held);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.product_out !== 64'd0 ||
        bus.fits_out !== 1'b1) begin
      errors++;
      $display("FAIL zero_a got done=%b %h fits %b want 1 0 1",
               bus.done, bus.product_out, bus.fits_out);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start;
    int n0; int cyc; int lat; longint t; bit dr;
    n0 = n_done;
    bus.start = 1'b1;
    bus.a_in  = 32'd3;
    bus.b_in  = 32'd4;
    bus.c_in  = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle got ready=%b done=%b want 1 0",
               bus.ready, bus.done);
    end
    checks++;
    if (bus.product_out !== 64'd12 || n_done - n0 != 1) begin
      errors++;
      $display("FAIL busy_result got %0d dones %0d want 12 dones 1",
               bus.product_out, n_done - n0);
    end
    run_op(32'd5, 32'd6, 32'd7, lat, t, dr);
    checks++;
    if (bus.product_out !== 64'd37 || lat != LAT) begin
      errors++;
      $display("FAIL busy_next got %0d lat %0d want 37 lat %0d",
               bus.product_out, lat, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n0; int lat; longint t; bit dr;
    bus.start = 1'b1;
    bus.a_in  = 32'hFFFF0000;
    bus.b_in  = 32'h0000FFFF;
    bus.c_in  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.product_out !== '0 || bus.fits_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got r=%b d=%b p=%h f=%b want 1 0 0 1",
               bus.ready, bus.done, bus.product_out, bus.fits_out);
    end
    @(negedge clk);
    reset = 1'b0;
    n0 = n_done;
    repeat (40) @(negedge clk);
    checks++;
    if (n_done != n0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done got dones %0d ready %b want 0 1",
               n_done - n0, bus.ready);
    end
    run_op(32'd6, 32'd7, 32'd1, lat, t, dr);
    checks++;
    if (bus.product_out !== 64'd43 || lat != LAT) begin
      errors++;
      $display("FAIL abort_next got %0d lat %0d want 43 lat %0d",
               bus.product_out, lat, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat; longint t0; longint t1; bit dr;
    logic [W2-1:0] exp_p;
    run_op(32'd1000, 32'd1000, 32'd1, lat, t0, dr);
    @(negedge clk);
    exp_p = ref_mac(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF);
    run_op(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, lat, t1, dr);
    checks++;
    if ((t1 - t0) / 10 != W + 3) begin
      errors++;
      $display("FAIL b2b_interval got %0d want %0d", (t1 - t0) / 10, W + 3);
    end
    checks++;
    if (bus.product_out !== exp_p) begin
      errors++;
      $display("FAIL b2b_product got %h want %h", bus.product_out, exp_p);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0]  a, b, c;
    logic [W2-1:0] exp_p;
    int lat; longint t; bit dr;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      c = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      if ($urandom_range(0, 5) == 0) b = W'($urandom_range(0, 3));
      exp_p = ref_mac(a, b, c);
      run_op(a, b, c, lat, t, dr);
      checks++;
      if (bus.product_out !== exp_p || bus.fits_out !== ref_fits(exp_p) ||
          lat != LAT) begin
        errors++;
        $display("FAIL rand%0d got %h f%b lat %0d want %h f%b lat %0d",
                 i, bus.product_out, bus.fits_out, lat,
                 exp_p, ref_fits(exp_p), LAT);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_done = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_zero_hold();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_add.md
Name: seq_mul_add

Overview:
Multi-cycle unsigned shift-and-add multiply-accumulate that computes product = a*b + c. It is the inverse datapath of the team's sequential divider: feeding it quotient, divisor and remainder reconstructs the dividend. It is used for divider self-check and for general scaling in the arithmetic unit. Each operation runs one multiply iteration per clock with a start/ready/done handshake.

Parameters:
WIDTH, 32, operand width in bits. Legal values are at least 2. Result width is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only when ready=1
a_in  input  WIDTH  multiplicand (unsigned)
b_in  input  WIDTH  multiplier (unsigned)
c_in  input  WIDTH  addend (unsigned, zero-extended to 2*WIDTH)
product_out  output  2*WIDTH  registered result a*b+c
fits_out  output  1  1 when product_out[2*WIDTH-1:WIDTH] == 0
ready  output  1  1 when idle and able to accept start
done  output  1  one-cycle pulse marking that product_out/fits_out have just been updated

Behaviour:
- Reset (async assert, sync release): state=IDLE, iteration counter=0, internal operand regs=0, product_out=0, fits_out=1, done=0, ready=1.
- States: IDLE, MUL, ADD, DONE. ready = (state==IDLE). done = (state==DONE).
- IDLE: at an edge with start=1:
  - capture a_in, b_in, c_in.
  - clear accumulator (WIDTH+1-bit hi part incl. carry, WIDTH-bit lo part holding the multiplier).
  - count=0; go to MUL.
  - start=0: stay in IDLE.
- MUL, one iteration per edge:
  - if lo[0]==1, hi = hi + a (WIDTH+1 bits, carry kept).
  - shift {carry,hi,lo} right by 1.
  - count++.
  - after WIDTH iterations (count reaches WIDTH) go to ADD.
- ADD, one edge:
  - product_out = {hi,lo} + zero_ext(c); fits_out computed from the new value.
  - go to DONE.
  - The sum never exceeds 2^(2*WIDTH)-1, so no overflow output is needed.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: if the accept edge is E0, done is high in the cycle after edge E(WIDTH+1), i.e. 33 edges after accept for WIDTH=32. ready returns high one cycle later. Back-to-back issue interval is WIDTH+3 cycles.
- start while ready=0 (MUL, ADD or DONE) is ignored: no queuing, no effect on the operation in flight.
- Input ports are don't-care except at the accept edge. Operands are held internally, so changing a_in/b_in/c_in mid-operation has no effect.
- product_out and fits_out hold their previous value from accept until the ADD edge, then hold the new value until the next ADD edge.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced for the aborted operation.
- b=0 yields product=c. a=0 yields product=c. WIDTH iterations always run; there is no early termination.

Test Plan:
- a=25, b=2, c=0, start for 1 cycle -> ready drops next cycle; done pulses exactly once 33 edges after accept; product_out=50, fits_out=1; ready=1 the following cycle.
- Divider reconstruction: a=7, b=3, c=2 -> product_out=23, fits_out=1. a=0x0000FFFF, b=0x00010001, c=0 -> product_out=0xFFFFFFFF, fits_out=1.
- Max operands: a=b=c=0xFFFFFFFF -> product_out=0xFFFFFFFF00000000, fits_out=0, no wrap. a=0x80000000, b=2, c=0 -> product_out=0x1_00000000, fits_out=0.
- Zero cases: a=0x12345678, b=0, c=5 -> product_out=5. Then a=0, b=9, c=0 -> product_out=0, fits_out=1. Previous result held on product_out until the new done.
- Start while busy: issue a=3, b=4, c=0; pulse start with a=100, b=100 at cycles 5 and 34 (DONE cycle) -> only one done, product_out=12. A start in the first ready cycle after that is accepted normally.
- Reset at cycle 10 of an operation -> ready=1, done=0, product_out=0, fits_out=1 immediately; no later done pulse. A following op a=6, b=7, c=1 -> product_out=43 with nominal latency.
